// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back/commit stage.
// Holds the commit FSM encoding and fixed register/PC constants.
package wb_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    RESUME = 2'd2
  } wb_state_e;

  localparam logic [4:0]  REG_RA    = 5'd31;
  localparam logic [31:0] HALT_CODE = 32'd10;
  localparam logic [31:0] DISP_CODE = 32'd34;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/wb_counter.sv
// Synchronous-reset wrapping counter with increment enable.
// Ports: clk, rst, en_i (increment), cnt_o (current count).
module wb_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign cnt_d = en_i ? cnt_q + 1'b1 : cnt_q;
  assign cnt_o = cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_commit_unit.sv
// Write-back/commit stage: register-file write port, syscall
// display/halt services, pipeline freeze and commit statistics.
// Inputs : clk, rst, MEM/WB fields (effective_i, ir_i, pc_i,
//          syscall_i, jal_i, regwrite_i, wb_data_i, r1_i, r2_i,
//          rd_no_i), go_i resume pulse.
// Outputs: rf_we_o/rf_waddr_o/rf_wdata_o, freeze_o, halted_o,
//          disp_o, cycle_cnt_o, instr_cnt_o.
// Macro WB_PERF_CNT_EN adds jal_cnt_o and sys_cnt_o.
module wb_commit_unit
  import wb_pkg::*;
#(
  parameter int          CNT_W     = 32,
  parameter logic [31:0] HALT_CODE = wb_pkg::HALT_CODE,
  parameter logic [31:0] DISP_CODE = wb_pkg::DISP_CODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             effective_i,
  input  logic [31:0]      ir_i,
  input  logic [31:0]      pc_i,
  input  logic             syscall_i,
  input  logic             jal_i,
  input  logic             regwrite_i,
  input  logic [31:0]      wb_data_i,
  input  logic [31:0]      r1_i,
  input  logic [31:0]      r2_i,
  input  logic [4:0]       rd_no_i,
  input  logic             go_i,
  output logic             rf_we_o,
  output logic [4:0]       rf_waddr_o,
  output logic [31:0]      rf_wdata_o,
  output logic             freeze_o,
  output logic             halted_o,
  output logic [31:0]      disp_o,
`ifdef WB_PERF_CNT_EN
  output logic [CNT_W-1:0] jal_cnt_o,
  output logic [CNT_W-1:0] sys_cnt_o,
`endif
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  wb_state_e   state_q;
  logic        halted_q;
  logic [31:0] disp_q;
  logic        halt_req;
  logic        disp_req;
  logic        retire;
  logic        unused_ir;

  // ir_i travels with the instruction for debug visibility only
  assign unused_ir = ^ir_i;

  assign halt_req = effective_i & syscall_i & (r1_i == HALT_CODE);
  assign disp_req = effective_i & syscall_i & (r1_i == DISP_CODE);

  assign rf_waddr_o = jal_i ? REG_RA : rd_no_i;
  assign rf_wdata_o = jal_i ? pc_i + PC_STEP : wb_data_i;
  assign rf_we_o    = effective_i & (regwrite_i | jal_i)
                    & (rf_waddr_o != 5'd0)
                    & (state_q != HALTED);

  // Halting syscall stays in WB (frozen) until the RESUME cycle
  assign freeze_o = (state_q == HALTED)
                  | ((state_q == RUN) & halt_req);

  assign retire = effective_i
                & (((state_q == RUN) & ~halt_req)
                  | (state_q == RESUME));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: if (halt_req) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end
        HALTED: if (go_i) begin
          state_q  <= RESUME;
          halted_q <= 1'b0;
        end
        RESUME: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
        default: begin
          state_q  <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                  disp_q <= '0;
    else if (retire & disp_req) disp_q <= r2_i;
  end

  assign halted_o = halted_q;
  assign disp_o   = disp_q;

  wb_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q != HALTED),
    .cnt_o (cycle_cnt_o)
  );

  wb_counter #(.W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (retire),
    .cnt_o (instr_cnt_o)
  );

`ifdef WB_PERF_CNT_EN
  wb_counter #(.W(CNT_W)) u_jal_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (retire & jal_i),
    .cnt_o (jal_cnt_o)
  );

  wb_counter #(.W(CNT_W)) u_sys_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (retire & syscall_i),
    .cnt_o (sys_cnt_o)
  );
`endif

endmodule

// File: tb/tb_wb_commit_unit.sv
// Self-checking bench for wb_commit_unit.
// Scoreboard of expected write-port/freeze values per cycle.
module tb_wb_commit_unit;

  logic        clk = 1'b0;
  logic        rst, eff, sys, jal, rw, go;
  logic [31:0] ir, pc, wbd, r1, r2;
  logic [4:0]  rd;

  logic        we, fz, hlt;
  logic [4:0]  wa;
  logic [31:0] wd, disp;
  logic [31:0] cyc_c, ins_c;

  logic        s_we, s_fz, s_hlt;
  logic [4:0]  s_wa;
  logic [31:0] s_wd, s_disp;
  logic [3:0]  s_cyc, s_ins;

`ifdef WB_PERF_CNT_EN
  logic [31:0] jal_c, sys_c;
  logic [3:0]  s_jal, s_sys;
`endif

  always #5 clk = ~clk;

  wb_commit_unit u_dut (
    .clk(clk), .rst(rst), .effective_i(eff), .ir_i(ir),
    .pc_i(pc), .syscall_i(sys), .jal_i(jal),
    .regwrite_i(rw), .wb_data_i(wbd), .r1_i(r1), .r2_i(r2),
    .rd_no_i(rd), .go_i(go), .rf_we_o(we), .rf_waddr_o(wa),
    .rf_wdata_o(wd), .freeze_o(fz), .halted_o(hlt),
    .disp_o(disp),
`ifdef WB_PERF_CNT_EN
    .jal_cnt_o(jal_c), .sys_cnt_o(sys_c),
`endif
    .cycle_cnt_o(cyc_c), .instr_cnt_o(ins_c)
  );

  // Narrow-counter instance so wrap-around is reachable
  wb_commit_unit #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .effective_i(eff), .ir_i(ir),
    .pc_i(pc), .syscall_i(sys), .jal_i(jal),
    .regwrite_i(rw), .wb_data_i(wbd), .r1_i(r1), .r2_i(r2),
    .rd_no_i(rd), .go_i(go), .rf_we_o(s_we), .rf_waddr_o(s_wa),
    .rf_wdata_o(s_wd), .freeze_o(s_fz), .halted_o(s_hlt),
    .disp_o(s_disp),
`ifdef WB_PERF_CNT_EN
    .jal_cnt_o(s_jal), .sys_cnt_o(s_sys),
`endif
    .cycle_cnt_o(s_cyc), .instr_cnt_o(s_ins)
  );

  typedef struct {
    logic        we;
    logic [4:0]  a;
    logic [31:0] d;
    logic        fz;
  } exp_t;

  exp_t q[$];

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: 0=RUN 1=HALTED 2=RESUME
  int          m_st;
  logic [31:0] m_cyc, m_ins, m_disp, m_jal, m_sys;

  task automatic idle();
    eff = 0; sys = 0; jal = 0; rw = 0; go = 0;
    ir = 32'h0; pc = 32'h0; wbd = 32'h0;
    r1 = 32'h0; r2 = 32'h0; rd = 5'd0;
  endtask

  // One clock with the current inputs; checks comb then state
  task automatic step();
    exp_t e, g;
    bit hreq, dreq, ret;
    hreq = eff && sys && (r1 == 32'd10);
    dreq = eff && sys && (r1 == 32'd34);
    e.a  = jal ? 5'd31 : rd;
    e.d  = jal ? pc + 32'd4 : wbd;
    e.we = eff && (rw || jal) && (e.a != 5'd0) && (m_st != 1);
    e.fz = (m_st == 1) || (m_st == 0 && hreq);
    q.push_back(e);
    #1;
    g = q.pop_front();
    n_chk++;
    if ({we, wa, wd, fz} !== {g.we, g.a, g.d, g.fz})
      $display("FAIL wport: got we=%b a=%0d d=%h fz=%b want we=%b a=%0d d=%h fz=%b",
               we, wa, wd, fz, g.we, g.a, g.d, g.fz);
    else n_pass++;
    ret = eff && ((m_st == 0 && !hreq) || m_st == 2);
    if (rst) begin
      m_st = 0; m_cyc = 0; m_ins = 0; m_disp = 0;
      m_jal = 0; m_sys = 0;
    end else begin
      if (m_st != 1) m_cyc++;
      if (ret) m_ins++;
      if (ret && jal) m_jal++;
      if (ret && sys) m_sys++;
      if (ret && dreq) m_disp = r2;
      case (m_st)
        0: if (hreq) m_st = 1;
        1: if (go) m_st = 2;
        default: m_st = 0;
      endcase
    end
    @(posedge clk);
    #1;
    n_chk++;
    if ({hlt, cyc_c, ins_c, disp, s_cyc} !==
        {(m_st == 1), m_cyc, m_ins, m_disp, m_cyc[3:0]})
      $display("FAIL state: got h=%b cyc=%0d ins=%0d disp=%h sc=%0d want h=%b cyc=%0d ins=%0d disp=%h sc=%0d",
               hlt, cyc_c, ins_c, disp, s_cyc, (m_st == 1),
               m_cyc, m_ins, m_disp, m_cyc[3:0]);
    else n_pass++;
`ifdef WB_PERF_CNT_EN
    n_chk++;
    if ({jal_c, sys_c} !== {m_jal, m_sys})
      $display("FAIL perf: got j=%0d s=%0d want j=%0d s=%0d",
               jal_c, sys_c, m_jal, m_sys);
    else n_pass++;
`endif
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_st = 0; m_cyc = 0; m_ins = 0; m_disp = 0;
    m_jal = 0; m_sys = 0;
    n_chk++;
    if ({hlt, fz, cyc_c, ins_c, disp} !== {1'b0, 1'b0, 96'h0})
      $display("FAIL reset: got h=%b fz=%b cyc=%0d ins=%0d disp=%h want all zero",
               hlt, fz, cyc_c, ins_c, disp);
    else n_pass++;
    rst = 0;
  endtask

  task automatic test_alu_write();
    idle(); eff = 1; rw = 1; rd = 5'd8; wbd = 32'h1234;
    step();
    rd = 5'd17; wbd = 32'hDEADBEEF;
    step();
  endtask

  task automatic test_zero_suppress();
    idle(); eff = 1; rw = 1; rd = 5'd0; wbd = 32'h55;
    step();
  endtask

  task automatic test_jal();
    idle(); eff = 1; jal = 1; pc = 32'h0000_3000; rd = 5'd4;
    step();
    pc = 32'hFFFF_FFFC;
    step();
  endtask

  task automatic test_display();
    idle(); eff = 1; sys = 1; r1 = 32'd34; r2 = 32'hCAFEF00D;
    step();
    idle();
    step();
  endtask

  task automatic test_bubble();
    idle(); sys = 1; r1 = 32'd10; rw = 1; rd = 5'd3;
    step();
    r1 = 32'd34; r2 = 32'h1111_2222;
    step();
  endtask

  task automatic test_halt_resume();
    idle(); eff = 1; sys = 1; r1 = 32'd10; rw = 1; rd = 5'd2;
    step();
    for (int i = 0; i < 5; i++) step();
    go = 1;
    step();
    go = 0;
    step();
    idle();
    step();
  endtask

  task automatic test_go_held();
    idle(); go = 1;
    step();
    eff = 1; sys = 1; r1 = 32'd10;
    step();
    step();
    step();
    idle(); go = 1; eff = 1; rw = 1; rd = 5'd9;
    step();
    idle();
    step();
  endtask

  task automatic test_reset_mid_halt();
    idle(); eff = 1; sys = 1; r1 = 32'd34; r2 = 32'h77;
    step();
    r1 = 32'd10;
    step();
    step();
    rst = 1;
    step();
    rst = 0;
    idle();
    step();
  endtask

  task automatic test_wrap();
    idle();
    rst = 1;
    step();
    rst = 0;
    for (int i = 0; i < 15; i++) step();
    n_chk++;
    if (s_cyc !== 4'hF)
      $display("FAIL wrap_pre: got %0d want 15", s_cyc);
    else n_pass++;
    step();
    n_chk++;
    if (s_cyc !== 4'h0)
      $display("FAIL wrap: got %0d want 0", s_cyc);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_zero_suppress();
    test_jal();
    test_display();
    test_bubble();
    test_halt_resume();
    test_go_held();
    test_reset_mid_halt();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
